// File: rtl/bcd_pkg.sv
// Shared types, constants and seven-segment decode for the serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } bcd_state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR  = 4'd6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 0 = segment a; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_seg7(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
    if (t > {1'b0, DIGIT_MAX}) begin
      // Adding 6 modulo 16 is the same as subtracting 10 modulo 16.
      sum_o = t[3:0] + BCD_CORR;
      c_o   = 1'b1;
    end else begin
      sum_o = t[3:0];
      c_o   = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, one digit per clock, LSD first.
// Optional subtraction (op port) is compiled in with macro BCD_SUB_EN.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef BCD_SUB_EN
  input  logic                op,
`endif
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [7*DIGITS-1:0] hex
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  bcd_state_e state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, op_q, op_d;
  logic            err_acc_q, err_acc_d, err_q, err_d, cout_q, cout_d;

  logic            op_in;
  logic [3:0]      b_eff, dig_sum;
  logic            dig_carry, dig_bad;
  logic [W-1:0]    res_shift;

`ifdef BCD_SUB_EN
  assign op_in = op;
`else
  assign op_in = 1'b0;
`endif

  // Subtraction adds the nines' complement of b with a forced carry-in.
  assign b_eff     = op_q ? (DIGIT_MAX - b_q[3:0]) : b_q[3:0];
  assign dig_bad   = (a_q[3:0] > DIGIT_MAX) || (b_q[3:0] > DIGIT_MAX);
  assign res_shift = W'({dig_sum, res_q} >> 4);

  bcd_digit_add u_digit_add (
    .a_i   (a_q[3:0]),
    .b_i   (b_eff),
    .c_i   (carry_q),
    .sum_o (dig_sum),
    .c_o   (dig_carry)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    op_d      = op_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
    cout_d    = cout_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d   = StAdd;
          a_d       = a;
          b_d       = b;
          op_d      = op_in;
          carry_d   = op_in ? 1'b1 : cin;
          idx_d     = '0;
          err_d     = 1'b0;
          err_acc_d = 1'b0;
        end
      end
      StAdd: begin
        a_d       = a_q >> 4;
        b_d       = b_q >> 4;
        res_d     = res_shift;
        carry_d   = dig_carry;
        err_acc_d = err_acc_q | dig_bad;
        idx_d     = idx_q + IdxOne;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          sum_d   = res_shift;
          cout_d  = dig_carry;
          err_d   = err_acc_q | dig_bad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= 1'b0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
      cout_q    <= cout_d;
    end
  end

  assign busy = (state_q == StAdd);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

  always_comb begin
    hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex[7*i +: 7] = bcd_seg7(sum_q[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: decimal reference model, queued expectations.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               cin   = 1'b0;
  logic [W-1:0]       a     = '0;
  logic [W-1:0]       b     = '0;
  logic               busy, done, cout, err;
  logic [W-1:0]       sum;
  logic [7*DIGITS-1:0] hex;
`ifdef BCD_SUB_EN
  logic               op    = 1'b0;
`endif

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef BCD_SUB_EN
    .op    (op),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err),
    .hex   (hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         er;
    int           edge_n;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint       x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_hex(input logic [W-1:0] s);
    logic [7*DIGITS-1:0] h = '0;
    logic [3:0]          d;
    for (int i = 0; i < DIGITS; i++) begin
      d = s[4*i +: 4];
      h[7*i +: 7] = (d < 10) ? seg_tab[d] : 7'h7F;
    end
    return h;
  endfunction

  // Valid operands use plain decimal arithmetic; invalid digits follow the per-digit rule.
  task automatic model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                       input logic rop, output logic [W-1:0] s, output logic co,
                       output logic er);
    longint lim = 1;
    longint va, vb, tot;
    int     c, t, bi;
    er = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      lim = lim * 10;
      if (ra[4*i +: 4] > 9 || rb[4*i +: 4] > 9) er = 1'b1;
    end
    if (!er) begin
      va = bcd2int(ra);
      vb = bcd2int(rb);
      if (rop) begin
        tot = va - vb;
        co  = (tot >= 0);
        s   = int2bcd(tot >= 0 ? tot : lim + tot);
      end else begin
        tot = va + vb + longint'(rc);
        co  = (tot >= lim);
        s   = int2bcd(tot % lim);
      end
    end else begin
      c = rop ? 1 : int'(rc);
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
        bi = rop ? ((9 - int'(rb[4*i +: 4])) & 15) : int'(rb[4*i +: 4]);
        t  = int'(ra[4*i +: 4]) + bi + c;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t - 10) & 15);
          c = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
      co = c[0];
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_edge", 64'(cyc), 64'(e.edge_n + DIGITS));
          chk("sum", 64'(sum), 64'(e.s));
          chk("cout", 64'(cout), 64'(e.co));
          chk("err", 64'(err), 64'(e.er));
          chk("hex", 64'(hex), 64'(exp_hex(e.s)));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                       input logic rop, input bit expect_res);
    exp_t         e;
    logic [W-1:0] s;
    logic         co, er;
    @(negedge clk);
    a     = ra;
    b     = rb;
    cin   = rc;
`ifdef BCD_SUB_EN
    op    = rop;
`endif
    start = 1'b1;
    if (expect_res) begin
`ifdef BCD_SUB_EN
      model(ra, rb, rc, rop, s, co, er);
`else
      model(ra, rb, rc, 1'b0, s, co, er);
`endif
      e.s      = s;
      e.co     = co;
      e.er     = er;
      e.edge_n = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                        input logic rop);
    int nb;
    issue(ra, rb, rc, rop, 1'b1);
    nb = int'(busy);
    repeat (DIGITS) begin
      @(negedge clk);
      nb += int'(busy);
    end
    chk("busy_cycles", 64'(nb), 64'(DIGITS));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    int d0;
    logic rop;
    repeat (3) @(negedge clk);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_hex", 64'(hex), 64'(exp_hex('0)));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    run_op(16'h1111, 16'h2222, 1'b1, 1'b0);
`ifdef BCD_SUB_EN
    run_op(16'h0100, 16'h0001, 1'b0, 1'b1);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b1);
`endif

    // start pulsed mid-operation must not disturb the result or add a done
    d0 = done_cnt;
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a     = 16'h9999;
    b     = 16'h9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 3) @(negedge clk);
    chk("ignored_start_dones", 64'(done_cnt - d0), 64'd1);

    // reset dropped with the digit index at 2
    issue(16'h5555, 16'h4444, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIGITS + 3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));

    for (int n = 0; n < 150; n++) begin
`ifdef BCD_SUB_EN
      rop = 1'($urandom_range(0, 1));
`else
      rop = 1'b0;
`endif
      run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), rop);
    end

    repeat (DIGITS + 3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
